// File: rtl/serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor controller.
// State encodings and default operand width.
package serial_sub_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int SUB_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/full_subtractor_gate.sv
// Single-bit full subtractor cell.
// D = A - B - Bin (mod 2), Bout = borrow out.
module full_subtractor_gate (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  assign D    = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor: one full_subtractor_gate reused
// over WIDTH cycles, LSB first, start/done handshake.
module serial_subtractor_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             brw;
  logic             d;
  logic             bout;
  logic             accept;
  logic             last;

  full_subtractor_gate u_cell (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .Bin  (brw),
    .D    (d),
    .Bout (bout)
  );

  assign accept = start &&
                  ((state == ST_IDLE) ||
                   (state == ST_DONE));
  assign last   = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE: state_nxt = start ? ST_RUN : ST_IDLE;
      ST_RUN:  state_nxt = last ? ST_DONE : ST_RUN;
      ST_DONE: state_nxt = start ? ST_RUN : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_RUN:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Result bits enter from the MSB side so bit 0 lands last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      brw        <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      a_sh   <= a;
      b_sh   <= b;
      res_sh <= '0;
      brw    <= bin;
    end else if (state == ST_RUN) begin
      res_sh <= {d, res_sh[WIDTH-1:1]};
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      brw    <= bout;
      if (!last) cnt <= cnt + 1'b1;
      if (last) begin
        diff       <= {d, res_sh[WIDTH-1:1]};
        borrow_out <= bout;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed + random bench for serial_subtractor_ctrl,
// 8-bit instance plus a 4-bit instance for a full sweep.
module tb_serial_subtractor_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       bin8 = 1'b0;
  logic       busy8;
  logic       done8;
  logic [7:0] diff8;
  logic       bo8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       bin4 = 1'b0;
  logic       busy4;
  logic       done4;
  logic [3:0] diff4;
  logic       bo4;

  int errors = 0;
  int checks = 0;
  logic [7:0] last_d = '0;

  always #5 clk = ~clk;

  serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start8),
    .a          (a8),
    .b          (b8),
    .bin        (bin8),
    .busy       (busy8),
    .done       (done8),
    .diff       (diff8),
    .borrow_out (bo8)
  );

  serial_subtractor_ctrl #(.WIDTH(4)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start4),
    .a          (a4),
    .b          (b4),
    .bin        (bin4),
    .busy       (busy4),
    .done       (done4),
    .diff       (diff4),
    .borrow_out (bo4)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic on integers.
  function automatic int ref_diff(input int w, input int x,
                                  input int y, input int c);
    int m;
    m = 1 << w;
    return ((x - y - c) % m + m) % m;
  endfunction

  function automatic int ref_borrow(input int x, input int y,
                                    input int c);
    return (x < y + c) ? 1 : 0;
  endfunction

  // Drives one op on dut8; the next call lands in its DONE cycle.
  task automatic do8(input logic [7:0] ai, input logic [7:0] bi,
                     input logic bni, input bit hold,
                     input bit scr);
    int ed;
    int eb;
    ed = ref_diff(8, int'(ai), int'(bi), int'(bni));
    eb = ref_borrow(int'(ai), int'(bi), int'(bni));
    @(negedge clk);
    a8 = ai; b8 = bi; bin8 = bni; start8 = 1'b1;
    @(posedge clk); #1;
    chk("busy_after_start", 32'(busy8), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start8 = hold;
      if (scr && k == 3) begin
        a8 = 8'hAA; b8 = 8'h55;
      end
      @(posedge clk); #1;
      if (k < 8) begin
        chk("run_done_low", 32'(done8), 32'd0);
        chk("diff_held_in_run", 32'(diff8), 32'(last_d));
      end else begin
        chk("done_at_w", 32'(done8), 32'd1);
        chk("busy_low_done", 32'(busy8), 32'd0);
        chk("diff8", 32'(diff8), 32'(ed));
        chk("borrow8", 32'(bo8), 32'(eb));
      end
    end
    last_d = 8'(ed);
  endtask

  task automatic idle8(input int n);
    @(negedge clk);
    start8 = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    chk("idle_done_low", 32'(done8), 32'd0);
    chk("idle_busy_low", 32'(busy8), 32'd0);
    chk("idle_diff_held", 32'(diff8), 32'(last_d));
  endtask

  task automatic do4(input logic [3:0] ai, input logic [3:0] bi,
                     input logic bni);
    int ed;
    int eb;
    bit early;
    early = 1'b0;
    ed = ref_diff(4, int'(ai), int'(bi), int'(bni));
    eb = ref_borrow(int'(ai), int'(bi), int'(bni));
    @(negedge clk);
    a4 = ai; b4 = bi; bin4 = bni; start4 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start4 = 1'b0;
      @(posedge clk); #1;
      if (k < 4 && done4 !== 1'b0) early = 1'b1;
    end
    chk("sweep_no_early_done", 32'(early), 32'd0);
    chk("sweep_done", 32'(done4), 32'd1);
    chk("sweep_diff", 32'(diff4), 32'(ed));
    chk("sweep_borrow", 32'(bo4), 32'(eb));
  endtask

  initial begin
    int seen_done;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start8 = 1'($urandom); a8 = 8'($urandom);
      b8 = 8'($urandom); bin8 = 1'($urandom);
      start4 = 1'($urandom); a4 = 4'($urandom);
      b4 = 4'($urandom); bin4 = 1'($urandom);
    end
    #1;
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_diff", 32'(diff8), 32'd0);
    chk("rst_borrow", 32'(bo8), 32'd0);
    chk("rst_done4", 32'(done4), 32'd0);
    @(negedge clk);
    start8 = 1'b0; start4 = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    do8(8'h05, 8'h03, 1'b0, 1'b0, 1'b0);
    idle8(3);
    do8(8'h03, 8'h05, 1'b0, 1'b0, 1'b0);
    idle8(2);
    do8(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    do8(8'h80, 8'h7F, 1'b1, 1'b0, 1'b0);
    idle8(2);
    do8(8'h3C, 8'h21, 1'b0, 1'b1, 1'b1);
    do8(8'h10, 8'h01, 1'b0, 1'b0, 1'b0);
    idle8(2);

    for (int i = 0; i < 24; i++) begin
      do8(8'($urandom), 8'($urandom), 1'($urandom),
          1'b0, 1'($urandom));
      if ($urandom_range(1, 0) == 1) idle8($urandom_range(3, 1));
    end
    idle8(2);

    // Reset while the bit counter sits at 4.
    @(negedge clk);
    a8 = 8'h37; b8 = 8'h12; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy8), 32'd0);
    chk("midrst_done", 32'(done8), 32'd0);
    chk("midrst_diff", 32'(diff8), 32'd0);
    chk("midrst_borrow", 32'(bo8), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8 === 1'b1) seen_done++;
    end
    chk("midrst_no_done", 32'(seen_done), 32'd0);
    last_d = 8'h00;
    do8(8'hC8, 8'h64, 1'b1, 1'b0, 1'b0);
    idle8(2);

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++)
          do4(4'(x), 4'(y), 1'(c));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
